// File: rtl/alu_key_sequencer_pkg.sv
// Shared types for the ALU front panel: operand words, ALU opcodes and entry states.
// No logic; only types, constants and the switch-to-operand sign extension.
package alu_key_sequencer_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  aluop_t;

  localparam aluop_t ALU_SLL = 4'd0;

  typedef enum logic [1:0] {LOAD_A, LOAD_B, LOAD_OP, SHOW} entry_state_t;

  localparam int WORD_SIGN_EXT = 15;
  localparam int SW_OPERAND_W  = 17;

  function automatic word_t sign_ext_operand(input logic [SW_OPERAND_W-1:0] v);
    return {{WORD_SIGN_EXT{v[SW_OPERAND_W-1]}}, v};
  endfunction

endpackage

// File: rtl/alu_key_sequencer_if.sv
// Operand/opcode bus from the key sequencer into the ALU wrapper.
// Registered source, no backpressure: the ALU consumes whatever is presented.
interface alu_key_sequencer_if;
  import alu_key_sequencer_pkg::*;

  word_t      porta;
  word_t      portb;
  aluop_t     aluop;
  logic [1:0] state;
  logic       valid;

  modport master (output porta, output portb, output aluop, output state, output valid);
  modport slave  (input  porta, input  portb, input  aluop, input  state, input  valid);

endinterface

// File: rtl/alu_key_sequencer_key_debounce.sv
// Synchronizes and debounces one active-low key; press pulses on accepted 1->0 of the level.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES cycles from raw edge to press; no backpressure.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic CLK,
  input  logic nRST,
  input  logic raw_n,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   armed_q, armed_d;
  logic                   press_q, press_d;
  logic                   sync_lvl;

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], raw_n};
    fill_d  = {fill_q[SYNC_STAGES-2:0], 1'b1};
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync_lvl == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      level_d = sync_lvl;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // A key already held through reset must be seen released before it may fire.
    armed_d = armed_q | (fill_q[SYNC_STAGES-1] & sync_lvl);
    press_d = armed_q & level_q & ~level_d;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sync_q  <= '1;
      fill_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b1;
      armed_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      armed_q <= armed_d;
      press_q <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/alu_key_sequencer.sv
// Front-panel entry of A, B and opcode from switches, stepped by debounced enter/clear keys.
// Outputs update one cycle after a key event; valid pulses once per committed set; no backpressure.
module alu_key_sequencer
  import alu_key_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [3:0]            KEY,
  input  logic [17:0]           SW,
  alu_key_sequencer_if.master   alu
);

  localparam logic [1:0] ST_LOAD_A  = LOAD_A;
  localparam logic [1:0] ST_LOAD_B  = LOAD_B;
  localparam logic [1:0] ST_LOAD_OP = LOAD_OP;
  localparam logic [1:0] ST_SHOW    = SHOW;

  logic unused_inputs;
  assign unused_inputs = ^{KEY[3:2], SW[17]};

  logic enter_evt, clear_evt;
  logic enter_level_unused, clear_level_unused;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_enter (
    .CLK   (CLK),
    .nRST  (nRST),
    .raw_n (KEY[0]),
    .level (enter_level_unused),
    .press (enter_evt)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_clear (
    .CLK   (CLK),
    .nRST  (nRST),
    .raw_n (KEY[1]),
    .level (clear_level_unused),
    .press (clear_evt)
  );

  logic [SW_OPERAND_W-1:0] sw_sync_q [SYNC_STAGES];
  logic [SW_OPERAND_W-1:0] sw_sync_d [SYNC_STAGES];
  logic [SW_OPERAND_W-1:0] sw_sync;

  always_comb begin
    sw_sync_d[0] = SW[SW_OPERAND_W-1:0];
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sw_sync_d[i] = sw_sync_q[i-1];
    end
  end

  assign sw_sync = sw_sync_q[SYNC_STAGES-1];

  logic [1:0] state_q, state_d;
  word_t      porta_q, porta_d;
  word_t      portb_q, portb_d;
  aluop_t     aluop_q, aluop_d;
  logic       valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    porta_d = porta_q;
    portb_d = portb_q;
    aluop_d = aluop_q;
    valid_d = 1'b0;
    // Clear outranks enter when both land in the same cycle.
    if (clear_evt) begin
      state_d = ST_LOAD_A;
      porta_d = '0;
      portb_d = '0;
      aluop_d = ALU_SLL;
    end else if (enter_evt) begin
      case (state_q)
        ST_LOAD_A: begin
          porta_d = sign_ext_operand(sw_sync);
          state_d = ST_LOAD_B;
        end
        ST_LOAD_B: begin
          portb_d = sign_ext_operand(sw_sync);
          state_d = ST_LOAD_OP;
        end
        ST_LOAD_OP: begin
          aluop_d = aluop_t'(sw_sync[3:0]);
          valid_d = 1'b1;
          state_d = ST_SHOW;
        end
        default: state_d = ST_LOAD_A;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sw_sync_q[i] <= '1;
      end
      state_q <= ST_LOAD_A;
      porta_q <= '0;
      portb_q <= '0;
      aluop_q <= ALU_SLL;
      valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sw_sync_q[i] <= sw_sync_d[i];
      end
      state_q <= state_d;
      porta_q <= porta_d;
      portb_q <= portb_d;
      aluop_q <= aluop_d;
      valid_q <= valid_d;
    end
  end

  assign alu.porta = porta_q;
  assign alu.portb = portb_q;
  assign alu.aluop = aluop_q;
  assign alu.state = state_q;
  assign alu.valid = valid_q;

endmodule

// File: tb/tb_alu_key_sequencer.sv
// Bench for alu_key_sequencer: directed scenarios plus random key/switch traffic against a model.
module tb_alu_key_sequencer;

  localparam int DC = 4;
  localparam int SS = 2;

  logic        CLK;
  logic        nRST;
  logic [3:0]  KEY;
  logic [17:0] SW;

  alu_key_sequencer_if alu_bus ();

  alu_key_sequencer #(.DEBOUNCE_CYCLES(DC), .SYNC_STAGES(SS)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .KEY  (KEY),
    .SW   (SW),
    .alu  (alu_bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int valid_cnt = 0;

  // Reference model: entry step 0..3 and the three held values.
  int          m_st;
  logic [31:0] m_a, m_b;
  logic [3:0]  m_op;

  function automatic logic [31:0] ext17(input logic [16:0] v);
    logic [31:0] u;
    u = 32'(v);
    return v[16] ? u - 32'h0002_0000 : u;
  endfunction

  always @(negedge CLK) begin
    if (nRST === 1'b1 && alu_bus.valid === 1'b1) begin
      valid_cnt++;
      total++;
      if (alu_bus.state !== 2'd3) begin
        bad++;
        $display("FAIL valid_in_show state got=%0d exp=3", alu_bus.state);
      end
    end
  end

  task automatic press(input logic en, input logic cl, input logic [16:0] swv,
                       input int hold, input string nm);
    int v0;
    int exp_v;
    logic [3:0] side;
    @(negedge CLK);
    SW = {1'($urandom_range(0, 1)), swv};
    repeat (SS + 2) @(negedge CLK);
    v0 = valid_cnt;
    side = 4'($urandom);
    KEY = {side[3:2], ~cl, ~en};
    repeat (hold) @(negedge CLK);
    KEY = 4'hF;
    repeat (16) @(negedge CLK);
    exp_v = (en && !cl && m_st == 2) ? 1 : 0;
    if (cl) begin
      m_st = 0; m_a = '0; m_b = '0; m_op = '0;
    end else if (en) begin
      case (m_st)
        0: m_a = ext17(swv);
        1: m_b = ext17(swv);
        2: m_op = swv[3:0];
        default: ;
      endcase
      m_st = (m_st + 1) % 4;
    end
    total += 5;
    if (alu_bus.state !== 2'(m_st)) begin bad++; $display("FAIL %s state got=%0d exp=%0d", nm, alu_bus.state, m_st); end
    if (alu_bus.porta !== m_a) begin bad++; $display("FAIL %s porta got=%h exp=%h", nm, alu_bus.porta, m_a); end
    if (alu_bus.portb !== m_b) begin bad++; $display("FAIL %s portb got=%h exp=%h", nm, alu_bus.portb, m_b); end
    if (alu_bus.aluop !== m_op) begin bad++; $display("FAIL %s aluop got=%h exp=%h", nm, alu_bus.aluop, m_op); end
    if (valid_cnt - v0 != exp_v) begin bad++; $display("FAIL %s valid_cycles got=%0d exp=%0d", nm, valid_cnt - v0, exp_v); end
  endtask

  task automatic bounce_burst();
    for (int i = 0; i < 5; i++) begin
      KEY[0] = 1'b0; repeat (2) @(negedge CLK);
      KEY[0] = 1'b1; repeat (2) @(negedge CLK);
    end
    KEY = 4'hF;
    repeat (16) @(negedge CLK);
  endtask

  task automatic test_reset();
    nRST = 1'b0; KEY = 4'b0000; SW = '1;
    repeat (3) @(negedge CLK);
    total += 5;
    if (alu_bus.porta !== 32'h0) begin bad++; $display("FAIL reset porta got=%h exp=0", alu_bus.porta); end
    if (alu_bus.portb !== 32'h0) begin bad++; $display("FAIL reset portb got=%h exp=0", alu_bus.portb); end
    if (alu_bus.aluop !== 4'h0) begin bad++; $display("FAIL reset aluop got=%h exp=0", alu_bus.aluop); end
    if (alu_bus.state !== 2'd0) begin bad++; $display("FAIL reset state got=%0d exp=0", alu_bus.state); end
    if (alu_bus.valid !== 1'b0) begin bad++; $display("FAIL reset valid got=%b exp=0", alu_bus.valid); end
    nRST = 1'b1;
    repeat (20) @(negedge CLK);
    total++;
    if (alu_bus.state !== 2'd0) begin bad++; $display("FAIL reset_held_key state got=%0d exp=0", alu_bus.state); end
    KEY = 4'hF;
    repeat (16) @(negedge CLK);
    total++;
    if (alu_bus.state !== 2'd0) begin bad++; $display("FAIL reset_release state got=%0d exp=0", alu_bus.state); end
    m_st = 0; m_a = '0; m_b = '0; m_op = '0;
  endtask

  task automatic test_full_entry();
    press(1'b1, 1'b0, 17'h00005, 10, "entry_a");
    press(1'b1, 1'b0, 17'h1FFFF, 10, "entry_b");
    press(1'b1, 1'b0, 17'h00004, 10, "entry_op");
  endtask

  task automatic test_wrap();
    press(1'b1, 1'b0, 17'h0ABCD, 10, "wrap");
  endtask

  task automatic test_bounce();
    logic [31:0] a0;
    a0 = alu_bus.porta;
    SW = {1'b0, 17'h01234};
    bounce_burst();
    total += 2;
    if (alu_bus.state !== 2'd0) begin bad++; $display("FAIL bounce state got=%0d exp=0", alu_bus.state); end
    if (alu_bus.porta !== a0) begin bad++; $display("FAIL bounce porta got=%h exp=%h", alu_bus.porta, a0); end
  endtask

  task automatic test_hold();
    SW = {1'b0, 17'h00005};
    repeat (SS + 2) @(negedge CLK);
    KEY[0] = 1'b0;
    repeat (50) @(negedge CLK);
    m_a = 32'h5; m_st = 1;
    total += 2;
    if (alu_bus.state !== 2'd1) begin bad++; $display("FAIL hold state got=%0d exp=1", alu_bus.state); end
    if (alu_bus.porta !== 32'h5) begin bad++; $display("FAIL hold porta got=%h exp=5", alu_bus.porta); end
    KEY = 4'hF;
    repeat (16) @(negedge CLK);
    total++;
    if (alu_bus.state !== 2'd1) begin bad++; $display("FAIL hold_release state got=%0d exp=1", alu_bus.state); end
  endtask

  task automatic test_clear_priority();
    press(1'b1, 1'b0, 17'h00009, 10, "to_load_op");
    press(1'b1, 1'b1, 17'h00003, 10, "clear_both");
  endtask

  task automatic test_reset_mid_debounce();
    press(1'b1, 1'b0, 17'h00077, 10, "to_load_b");
    KEY[0] = 1'b0;
    repeat (4) @(negedge CLK);
    nRST = 1'b0;
    @(negedge CLK);
    total += 4;
    if (alu_bus.state !== 2'd0) begin bad++; $display("FAIL midrst state got=%0d exp=0", alu_bus.state); end
    if (alu_bus.porta !== 32'h0) begin bad++; $display("FAIL midrst porta got=%h exp=0", alu_bus.porta); end
    if (alu_bus.aluop !== 4'h0) begin bad++; $display("FAIL midrst aluop got=%h exp=0", alu_bus.aluop); end
    if (alu_bus.valid !== 1'b0) begin bad++; $display("FAIL midrst valid got=%b exp=0", alu_bus.valid); end
    nRST = 1'b1;
    repeat (12) @(negedge CLK);
    KEY = 4'hF;
    repeat (16) @(negedge CLK);
    m_st = 0; m_a = '0; m_b = '0; m_op = '0;
    total++;
    if (alu_bus.state !== 2'd0) begin bad++; $display("FAIL midrst_after state got=%0d exp=0", alu_bus.state); end
  endtask

  task automatic test_latency();
    int n;
    SW = {1'b0, 17'h00042};
    repeat (SS + 2) @(negedge CLK);
    KEY[0] = 1'b0;
    n = 0;
    while (alu_bus.state === 2'd0 && n < 30) begin
      @(negedge CLK);
      n++;
    end
    // Event at SS+DC (+-1), state registered one edge later.
    total++;
    if (n < SS + DC || n > SS + DC + 2) begin
      bad++; $display("FAIL latency cycles got=%0d exp=%0d..%0d", n, SS + DC, SS + DC + 2);
    end
    KEY = 4'hF;
    repeat (16) @(negedge CLK);
    m_a = 32'h42; m_st = 1;
    total++;
    if (alu_bus.porta !== 32'h42) begin bad++; $display("FAIL latency porta got=%h exp=42", alu_bus.porta); end
  endtask

  task automatic test_random();
    int r;
    logic [16:0] v;
    logic [31:0] a0;
    logic [1:0]  s0;
    for (int i = 0; i < 16; i++) begin
      r = $urandom_range(0, 9);
      v = 17'($urandom);
      if (r < 6)       press(1'b1, 1'b0, v, $urandom_range(8, 20), "rand_enter");
      else if (r < 8)  press(1'b0, 1'b1, v, $urandom_range(8, 20), "rand_clear");
      else if (r == 8) press(1'b1, 1'b1, v, $urandom_range(8, 20), "rand_both");
      else begin
        a0 = alu_bus.porta; s0 = alu_bus.state;
        bounce_burst();
        total += 2;
        if (alu_bus.state !== s0) begin bad++; $display("FAIL rand_bounce state got=%0d exp=%0d", alu_bus.state, s0); end
        if (alu_bus.porta !== a0) begin bad++; $display("FAIL rand_bounce porta got=%h exp=%h", alu_bus.porta, a0); end
      end
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0; KEY = 4'hF; SW = '0;
    test_reset();
    test_full_entry();
    test_wrap();
    test_bounce();
    test_hold();
    test_clear_priority();
    test_reset_mid_debounce();
    test_latency();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
